por_seq: RTL and testbench

POR_SEQ -- requirements
Module: por_seq

---
 rtl/por_seq.sv | 134 +++++++++++++
 tb/tb_por_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/por_seq.sv
// Power-on reset sequencer: qualifies synchronized supply-good inputs, then
// releases a chain of active-low resets one stage at a time, tracking brownouts.
module por_seq #(
   parameter int NCH   = 2,
   parameter int NSTG  = 3,
   parameter int CNT_W = 8
) (
   input  logic             osc_ck,
   input  logic             por,
   input  logic [NCH-1:0]   pwup_filt,
   input  logic             force_pdnb,
   input  logic [CNT_W-1:0] deb_len,
   input  logic [CNT_W-1:0] rel_dly,
   input  logic             bo_clr,
   output logic [NSTG-1:0]  porb_out,
   output logic             por_out,
   output logic             ready,
   output logic [1:0]       state,
   output logic [7:0]       bo_cnt,
   output logic [NCH-1:0]   ch_low
);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      QUAL    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } state_t;

   state_t           state_q;
   logic [NCH-1:0]   sync1;
   logic [NCH-1:0]   sync2;
   logic [CNT_W-1:0] deb_cnt;
   logic [CNT_W-1:0] rel_cnt;

   logic             all_ok;
   logic [CNT_W:0]   eff_deb;
   logic [CNT_W:0]   eff_rel;
   logic [CNT_W:0]   deb_nxt;
   logic [CNT_W:0]   rel_nxt;
   logic             deb_hit;
   logic             rel_hit;
   logic [NSTG-1:0]  nxt_porb;
   logic [7:0]       bo_base;
   logic [7:0]       bo_inc;
   logic [NCH-1:0]   ch_base;

   // Zero lengths behave as one; comparisons use >= so a shortened length
   // mid-count takes effect immediately and the counters never wrap.
   always_comb begin
      all_ok   = &sync2;
      eff_deb  = (deb_len == '0) ? (CNT_W+1)'(1) : {1'b0, deb_len};
      eff_rel  = (rel_dly == '0) ? (CNT_W+1)'(1) : {1'b0, rel_dly};
      deb_nxt  = {1'b0, deb_cnt} + 1'b1;
      rel_nxt  = {1'b0, rel_cnt} + 1'b1;
      deb_hit  = (deb_nxt >= eff_deb);
      rel_hit  = (rel_nxt >= eff_rel);
      nxt_porb = porb_out << 1;
      nxt_porb[0] = 1'b1;
      // A clear pulse lands before any same-cycle brownout event.
      bo_base  = bo_clr ? 8'd0 : bo_cnt;
      ch_base  = bo_clr ? '0 : ch_low;
      bo_inc   = (bo_base == 8'hFF) ? 8'hFF : bo_base + 8'd1;
   end

   always_ff @(posedge osc_ck or posedge por) begin
      if (por) begin
         state_q  <= HOLD;
         sync1    <= '0;
         sync2    <= '0;
         deb_cnt  <= '0;
         rel_cnt  <= '0;
         porb_out <= '0;
         bo_cnt   <= 8'd0;
         ch_low   <= '0;
      end else begin
         sync1  <= pwup_filt;
         sync2  <= sync1;
         bo_cnt <= bo_base;
         ch_low <= ch_base;
         if (!force_pdnb) begin
            state_q  <= HOLD;
            porb_out <= '0;
            deb_cnt  <= '0;
            rel_cnt  <= '0;
         end else begin
            case (state_q)
               HOLD: begin
                  state_q  <= QUAL;
                  porb_out <= '0;
                  deb_cnt  <= '0;
                  rel_cnt  <= '0;
               end
               QUAL: begin
                  if (!all_ok) begin
                     deb_cnt <= '0;
                  end else if (deb_hit) begin
                     state_q <= RELEASE;
                     deb_cnt <= '0;
                     rel_cnt <= '0;
                  end else begin
                     deb_cnt <= deb_nxt[CNT_W-1:0];
                  end
               end
               RELEASE, RUN: begin
                  if (!all_ok) begin
                     state_q  <= HOLD;
                     porb_out <= '0;
                     deb_cnt  <= '0;
                     rel_cnt  <= '0;
                     bo_cnt   <= bo_inc;
                     ch_low   <= ch_base | ~sync2;
                  end else if (state_q == RELEASE) begin
                     if (rel_hit) begin
                        porb_out <= nxt_porb;
                        rel_cnt  <= '0;
                        if (nxt_porb[NSTG-1])
                           state_q <= RUN;
                     end else begin
                        rel_cnt <= rel_nxt[CNT_W-1:0];
                     end
                  end
               end
               default: state_q <= HOLD;
            endcase
         end
      end
   end

   assign state   = state_q;
   assign ready   = (state_q == RUN);
   assign por_out = ~porb_out[NSTG-1];

endmodule

// File: tb/tb_por_seq.sv
// Directed bench for por_seq (NCH=2, NSTG=3, CNT_W=8) with hand-derived
// edge-by-edge expectations for power-up, glitches, brownouts and overrides.
module tb_por_seq;

   logic       osc_ck = 1'b0;
   logic       por;
   logic [1:0] pwup_filt;
   logic       force_pdnb;
   logic [7:0] deb_len;
   logic [7:0] rel_dly;
   logic       bo_clr;
   logic [2:0] porb_out;
   logic       por_out;
   logic       ready;
   logic [1:0] state;
   logic [7:0] bo_cnt;
   logic [1:0] ch_low;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [1:0] S_HOLD = 2'd0;
   localparam logic [1:0] S_QUAL = 2'd1;
   localparam logic [1:0] S_REL  = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   por_seq #(.NCH(2), .NSTG(3), .CNT_W(8)) dut (
      .osc_ck    (osc_ck),
      .por       (por),
      .pwup_filt (pwup_filt),
      .force_pdnb(force_pdnb),
      .deb_len   (deb_len),
      .rel_dly   (rel_dly),
      .bo_clr    (bo_clr),
      .porb_out  (porb_out),
      .por_out   (por_out),
      .ready     (ready),
      .state     (state),
      .bo_cnt    (bo_cnt),
      .ch_low    (ch_low)
   );

   always #5 osc_ck = ~osc_ck;

   task automatic tick();
      @(posedge osc_ck);
      #1;
   endtask

   // Edge n counted from the pwup_filt rise; RELEASE at deb_edge and one more
   // stage every step edges after that.
   task automatic run_powerup(input int deb_edge, input int step, input string tag);
      int stages;
      logic [1:0] exp_st;
      logic [2:0] exp_porb;
      for (int n = 1; n <= deb_edge + 3 * step; n++) begin
         tick();
         stages = (n < deb_edge) ? 0 : (n - deb_edge) / step;
         if (stages > 3) stages = 3;
         exp_st   = (n < deb_edge) ? S_QUAL : ((stages == 3) ? S_RUN : S_REL);
         exp_porb = 3'((1 << stages) - 1);
         n_cmp++;
         if (state !== exp_st) begin
            n_bad++;
            $display("[TB] FAIL %s_state edge %0d: got %0d expected %0d", tag, n, state, exp_st);
         end
         n_cmp++;
         if (porb_out !== exp_porb) begin
            n_bad++;
            $display("[TB] FAIL %s_porb edge %0d: got %b expected %b", tag, n, porb_out, exp_porb);
         end
         n_cmp++;
         if (ready !== (stages == 3) || por_out !== (stages != 3)) begin
            n_bad++;
            $display("[TB] FAIL %s_ready edge %0d: got ready=%b por_out=%b expected ready=%b",
                     tag, n, ready, por_out, (stages == 3));
         end
      end
   endtask

   task automatic test_reset();
      por = 1'b1; pwup_filt = 2'b00; force_pdnb = 1'b1;
      deb_len = 8'd4; rel_dly = 8'd2; bo_clr = 1'b0;
      tick(); tick();
      n_cmp++;
      if (state !== S_HOLD || porb_out !== 3'b000 || por_out !== 1'b1 || ready !== 1'b0 ||
          bo_cnt !== 8'd0 || ch_low !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL reset_values: got st=%0d porb=%b por_out=%b rdy=%b bo=%0d ch=%b expected 0 000 1 0 0 00",
                  state, porb_out, por_out, ready, bo_cnt, ch_low);
      end
      por = 1'b0;
      tick();
      n_cmp++;
      if (state !== S_QUAL) begin
         n_bad++;
         $display("[TB] FAIL reset_release: got %0d expected %0d", state, S_QUAL);
      end
      tick(); tick();
   endtask

   task automatic test_power_up();
      pwup_filt = 2'b11;
      run_powerup(6, 2, "powerup");
   endtask

   task automatic test_glitch();
      force_pdnb = 1'b0; pwup_filt = 2'b00;
      tick();
      force_pdnb = 1'b1;
      tick(); tick(); tick();
      pwup_filt = 2'b11;
      tick(); tick(); tick();
      pwup_filt = 2'b01;
      tick(); tick(); tick();
      n_cmp++;
      if (state !== S_QUAL || bo_cnt !== 8'd0) begin
         n_bad++;
         $display("[TB] FAIL glitch_qual: got st=%0d bo=%0d expected st=1 bo=0", state, bo_cnt);
      end
      pwup_filt = 2'b11;
      run_powerup(6, 2, "glitch");
   endtask

   task automatic test_brownout();
      pwup_filt = 2'b10;
      tick(); tick();
      n_cmp++;
      if (state !== S_RUN) begin
         n_bad++;
         $display("[TB] FAIL brownout_early: got %0d expected %0d", state, S_RUN);
      end
      tick();
      n_cmp++;
      if (state !== S_HOLD || porb_out !== 3'b000 || bo_cnt !== 8'd1 || ch_low !== 2'b01) begin
         n_bad++;
         $display("[TB] FAIL brownout_event: got st=%0d porb=%b bo=%0d ch=%b expected 0 000 1 01",
                  state, porb_out, bo_cnt, ch_low);
      end
      tick(); tick(); tick();
      pwup_filt = 2'b11;
      run_powerup(6, 2, "recover");
   endtask

   // One quick brownout: deb_len=0 makes RELEASE reachable in three edges.
   task automatic do_brownout(input logic clr);
      pwup_filt = 2'b11;
      tick(); tick(); tick();
      pwup_filt = 2'b00;
      tick(); tick();
      bo_clr = clr;
      tick();
      bo_clr = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      deb_len = 8'd0; rel_dly = 8'd200;
      pwup_filt = 2'b00;
      tick(); tick(); tick(); tick();
      bo_clr = 1'b1;
      tick();
      bo_clr = 1'b0;
      n_cmp++;
      if (bo_cnt !== 8'd0 || ch_low !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL clr_initial: got bo=%0d ch=%b expected 0 00", bo_cnt, ch_low);
      end
      for (int i = 0; i < 256; i++) begin
         do_brownout(1'b0);
         n_cmp++;
         if (bo_cnt !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
            n_bad++;
            $display("[TB] FAIL sat_count iter %0d: got %0d expected %0d", i, bo_cnt,
                     (i + 1 > 255) ? 255 : i + 1);
         end
      end
      n_cmp++;
      if (ch_low !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL sat_chlow: got %b expected 11", ch_low);
      end
      bo_clr = 1'b1;
      tick();
      bo_clr = 1'b0;
      n_cmp++;
      if (bo_cnt !== 8'd0 || ch_low !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL sat_clear: got bo=%0d ch=%b expected 0 00", bo_cnt, ch_low);
      end
      do_brownout(1'b0);
      do_brownout(1'b1);
      n_cmp++;
      if (bo_cnt !== 8'd1 || ch_low !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL clr_collision: got bo=%0d ch=%b expected 1 11", bo_cnt, ch_low);
      end
      deb_len = 8'd4; rel_dly = 8'd2;
   endtask

   task automatic test_force();
      pwup_filt = 2'b11;
      repeat (9) tick();
      n_cmp++;
      if (state !== S_REL || porb_out !== 3'b001) begin
         n_bad++;
         $display("[TB] FAIL force_pre: got st=%0d porb=%b expected 2 001", state, porb_out);
      end
      force_pdnb = 1'b0;
      tick();
      n_cmp++;
      if (state !== S_HOLD || porb_out !== 3'b000 || bo_cnt !== 8'd1) begin
         n_bad++;
         $display("[TB] FAIL force_hold: got st=%0d porb=%b bo=%0d expected 0 000 1", state, porb_out, bo_cnt);
      end
      force_pdnb = 1'b1;
      repeat (11) tick();
      n_cmp++;
      if (state !== S_RUN || porb_out !== 3'b111) begin
         n_bad++;
         $display("[TB] FAIL force_rerun: got st=%0d porb=%b expected 3 111", state, porb_out);
      end
   endtask

   task automatic test_force_brownout();
      pwup_filt = 2'b00;
      tick(); tick();
      force_pdnb = 1'b0;
      tick();
      n_cmp++;
      if (state !== S_HOLD || porb_out !== 3'b000 || bo_cnt !== 8'd1) begin
         n_bad++;
         $display("[TB] FAIL force_bo: got st=%0d porb=%b bo=%0d expected 0 000 1", state, porb_out, bo_cnt);
      end
      force_pdnb = 1'b1; pwup_filt = 2'b11;
      repeat (12) tick();
      n_cmp++;
      if (state !== S_RUN) begin
         n_bad++;
         $display("[TB] FAIL force_bo_rerun: got %0d expected %0d", state, S_RUN);
      end
   endtask

   task automatic test_por_mid_run();
      #2;
      por = 1'b1;
      #1;
      n_cmp++;
      if (state !== S_HOLD || porb_out !== 3'b000 || por_out !== 1'b1 || ready !== 1'b0 ||
          bo_cnt !== 8'd0 || ch_low !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL por_async: got st=%0d porb=%b por_out=%b rdy=%b bo=%0d ch=%b expected 0 000 1 0 0 00",
                  state, porb_out, por_out, ready, bo_cnt, ch_low);
      end
      tick();
      por = 1'b0;
      run_powerup(6, 2, "por_restart");
   endtask

   task automatic test_zero_len();
      force_pdnb = 1'b0; pwup_filt = 2'b00;
      tick(); tick(); tick();
      force_pdnb = 1'b1; deb_len = 8'd0; rel_dly = 8'd0;
      tick();
      pwup_filt = 2'b11;
      run_powerup(3, 1, "zero_len");
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_glitch();
      test_brownout();
      test_saturation();
      test_force();
      test_force_brownout();
      test_por_mid_run();
      test_zero_len();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
